// File: rtl/rv32_branch_pkg.sv
// Shared branch definitions.
// - Branch condition op codes (funct3 encodings of the RV32 conditional branches).
// - 2-bit direction counter width and the strong/weak taken/not-taken encodings.
// - Default counter value loaded when a predictor entry is allocated.
package rv32_branch_pkg;

   // Conditional branch op codes, taken directly from funct3.
   typedef enum logic [2:0] {
      BrEq  = 3'b000,
      BrNe  = 3'b001,
      BrLt  = 3'b100,
      BrGe  = 3'b101,
      BrLtu = 3'b110,
      BrGeu = 3'b111
   } br_op_e;

   localparam int unsigned CtrW = 2;

   // Bit 1 of the counter is the predicted direction.
   localparam logic [CtrW-1:0] CtrStrongNt = 2'b00;
   localparam logic [CtrW-1:0] CtrWeakNt   = 2'b01;
   localparam logic [CtrW-1:0] CtrWeakT    = 2'b10;
   localparam logic [CtrW-1:0] CtrStrongT  = 2'b11;

   localparam logic [CtrW-1:0] InitCtr = CtrWeakT;

endpackage

// File: rtl/rv32_branch_counter.sv
// Saturating 2-bit direction counter update.
// Ports:
//   ctr_i   - current counter value
//   taken_i - resolved branch outcome
//   ctr_o   - next counter value (up on taken, down on not taken, saturating)
module rv32_branch_counter
   import rv32_branch_pkg::*;
(
   input  logic [CtrW-1:0] ctr_i,
   input  logic            taken_i,
   output logic [CtrW-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CtrStrongT) begin
            ctr_o = ctr_i + 1'b1;
         end
      end else if (ctr_i != CtrStrongNt) begin
         ctr_o = ctr_i - 1'b1;
      end
   end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped branch target predictor with 2-bit direction counters.
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   lookup_pc_in        - fetch PC to predict (combinational lookup)
//   predict_taken_out   - predicted direction
//   predict_pc_out      - predicted next PC (target if taken, else PC+4)
//   update_valid_in     - a resolved branch/jump is presented this cycle
//   update_pc_in        - PC of the resolved instruction
//   update_taken_in     - actual outcome
//   update_target_in    - actual target
//   invalidate_in       - clear all entries and the hit counter
//   hit_count_out       - update-time tag hits since reset or invalidate
module rv32_branch_predictor
   import rv32_branch_pkg::*;
#(
   parameter int unsigned     ENTRIES  = 16,
   parameter logic [CtrW-1:0] INIT_CTR = InitCtr
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] lookup_pc_in,
   output logic        predict_taken_out,
   output logic [31:0] predict_pc_out,
   input  logic        update_valid_in,
   input  logic [31:0] update_pc_in,
   input  logic        update_taken_in,
   input  logic [31:0] update_target_in,
   input  logic        invalidate_in,
   output logic [31:0] hit_count_out
);

   localparam int unsigned IdxW = $clog2(ENTRIES);
   localparam int unsigned TagW = 30 - IdxW;

   // Table held in flops so reset and invalidate complete in one cycle.
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TagW-1:0]    tag_q    [ENTRIES];
   logic [TagW-1:0]    tag_d    [ENTRIES];
   logic [30:0]        target_q [ENTRIES];
   logic [30:0]        target_d [ENTRIES];
   logic [CtrW-1:0]    ctr_q    [ENTRIES];
   logic [CtrW-1:0]    ctr_d    [ENTRIES];
   logic [31:0]        hit_cnt_q, hit_cnt_d;

   // Lookup path: purely combinational from registered state, no update bypass.
   logic [IdxW-1:0] lk_idx;
   logic [TagW-1:0] lk_tag;
   logic            lk_hit;
   logic [CtrW-1:0] lk_ctr;
   logic [31:0]     pc_seq;

   assign lk_idx = lookup_pc_in[IdxW+1:2];
   assign lk_tag = lookup_pc_in[31:IdxW+2];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_ctr = ctr_q[lk_idx];
   assign pc_seq = lookup_pc_in + 32'd4;

   assign predict_taken_out = lk_hit && lk_ctr[1] && !reset;
   assign predict_pc_out    = predict_taken_out ? {target_q[lk_idx], 1'b0}
                                                : {pc_seq[31:1], 1'b0};
   assign hit_count_out     = hit_cnt_q;

   // Update path.
   logic [IdxW-1:0] up_idx;
   logic [TagW-1:0] up_tag;
   logic            up_hit;
   logic [CtrW-1:0] up_ctr_next;

   assign up_idx = update_pc_in[IdxW+1:2];
   assign up_tag = update_pc_in[31:IdxW+2];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Instruction alignment bits carry no information for the table.
   logic unused_bits;
   assign unused_bits = ^{update_pc_in[1:0], update_target_in[0]};

   rv32_branch_counter u_counter (
      .ctr_i   (ctr_q[up_idx]),
      .taken_i (update_taken_in),
      .ctr_o   (up_ctr_next)
   );

   always_comb begin
      valid_d   = valid_q;
      tag_d     = tag_q;
      target_d  = target_q;
      ctr_d     = ctr_q;
      hit_cnt_d = hit_cnt_q;
      if (invalidate_in) begin
         // Invalidate wins; a coincident update is dropped.
         valid_d   = '0;
         hit_cnt_d = '0;
      end else if (update_valid_in) begin
         if (up_hit) begin
            ctr_d[up_idx] = up_ctr_next;
            hit_cnt_d     = hit_cnt_q + 32'd1;
            if (update_taken_in) begin
               target_d[up_idx] = update_target_in[31:1];
            end
         end else if (update_taken_in) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = update_target_in[31:1];
            ctr_d[up_idx]    = INIT_CTR;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= '0;
         hit_cnt_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CtrStrongNt;
         end
      end else begin
         valid_q   <= valid_d;
         hit_cnt_q <= hit_cnt_d;
         tag_q     <= tag_d;
         target_q  <= target_d;
         ctr_q     <= ctr_d;
      end
   end

endmodule
